// File: rtl/nec_ir_tx_if.sv
// Request and status signals between an NEC IR transmitter and whoever drives it.
// 'repeat' is a reserved word, so the repeat-code request is carried as repeat_req.
interface nec_ir_tx_if;
    logic        start;
    logic        repeat_req;
    logic [15:0] customer;
    logic [7:0]  key;
    logic        ir_tx;
    logic        busy;
    logic        done;

    modport master (
        output start, repeat_req, customer, key,
        input  ir_tx, busy, done
    );

    modport slave (
        input  start, repeat_req, customer, key,
        output ir_tx, busy, done
    );
endinterface

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter, baseband only (no carrier). Sends a leader,
// 32 data bits LSB-first ({~key, key, customer}) and an end burst, or the
// short repeat code. The IR line is active low and idles high.
module nec_ir_tx #(
    parameter int LEADER_LO = 450000,
    parameter int LEADER_HI = 225000,
    parameter int REPEAT_HI = 112500,
    parameter int BIT_LO    = 28000,
    parameter int BIT0_HI   = 28000,
    parameter int BIT1_HI   = 84500,
    parameter int CNT_W     = 20
) (
    input  logic        clk_50M,
    input  logic        reset,
    nec_ir_tx_if.slave  bus
);

    // Counter reload values: a segment of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] C_LEAD_LO = CNT_W'(LEADER_LO - 1);
    localparam logic [CNT_W-1:0] C_LEAD_HI = CNT_W'(LEADER_HI - 1);
    localparam logic [CNT_W-1:0] C_RPT_HI  = CNT_W'(REPEAT_HI - 1);
    localparam logic [CNT_W-1:0] C_BIT_LO  = CNT_W'(BIT_LO - 1);
    localparam logic [CNT_W-1:0] C_BIT0_HI = CNT_W'(BIT0_HI - 1);
    localparam logic [CNT_W-1:0] C_BIT1_HI = CNT_W'(BIT1_HI - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_LO,
        S_LEAD_HI,
        S_BIT_LO,
        S_BIT_HI,
        S_END_LO
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [4:0]        idx_q, idx_d;
    logic              rpt_mode_q, rpt_mode_d;
    logic              ir_q, ir_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, counter reload and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        rpt_mode_d = rpt_mode_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shreg_d    = {~bus.key, bus.key, bus.customer};
                    idx_d      = '0;
                    rpt_mode_d = 1'b0;
                    state_d    = S_LEAD_LO;
                    cnt_d      = C_LEAD_LO;
                end else if (bus.repeat_req) begin
                    rpt_mode_d = 1'b1;
                    state_d    = S_LEAD_LO;
                    cnt_d      = C_LEAD_LO;
                end
            end
            S_LEAD_LO: begin
                if (cnt_q == '0) begin
                    state_d = S_LEAD_HI;
                    cnt_d   = rpt_mode_q ? C_RPT_HI : C_LEAD_HI;
                end
            end
            S_LEAD_HI: begin
                if (cnt_q == '0) begin
                    state_d = rpt_mode_q ? S_END_LO : S_BIT_LO;
                    cnt_d   = C_BIT_LO;
                end
            end
            S_BIT_LO: begin
                if (cnt_q == '0) begin
                    state_d = S_BIT_HI;
                    cnt_d   = shreg_q[0] ? C_BIT1_HI : C_BIT0_HI;
                end
            end
            S_BIT_HI: begin
                if (cnt_q == '0) begin
                    shreg_d = {1'b0, shreg_q[31:1]};
                    idx_d   = idx_q + 5'd1;
                    state_d = (idx_q == 5'd31) ? S_END_LO : S_BIT_LO;
                    cnt_d   = C_BIT_LO;
                end
            end
            S_END_LO: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the state being entered so each segment starts on its entry edge.
        ir_d   = !(state_d == S_LEAD_LO || state_d == S_BIT_LO || state_d == S_END_LO);
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers; reset forces the line high at once.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            idx_q      <= '0;
            rpt_mode_q <= 1'b0;
            ir_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            rpt_mode_q <= rpt_mode_d;
            ir_q       <= ir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.ir_tx = ir_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Bench for nec_ir_tx with shrunken segment durations. Stimulus pushes the
// expected line segments and frame summary into a queue; a monitor measures
// the IR line and pops/compares as segments and done pulses appear.
module tb_nec_ir_tx;

    localparam int LLO = 9;
    localparam int LHI = 6;
    localparam int RHI = 4;
    localparam int BLO = 2;
    localparam int B0  = 2;
    localparam int B1  = 5;

    logic clk_50M = 1'b0;
    logic reset   = 1'b1;

    nec_ir_tx_if bus ();

    nec_ir_tx #(
        .LEADER_LO(LLO), .LEADER_HI(LHI), .REPEAT_HI(RHI),
        .BIT_LO(BLO), .BIT0_HI(B0), .BIT1_HI(B1), .CNT_W(8)
    ) dut (
        .clk_50M(clk_50M),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        bit          is_done;
        bit          lvl;
        int          len;
        logic [31:0] word;
        int          nbits;
        int          busy_len;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_fail  = 0;
    int   idle_low = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seg(input bit l, input int n);
        exp_t e;
        e.is_done = 1'b0; e.lvl = l; e.len = n; e.word = '0; e.nbits = 0; e.busy_len = 0;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] w, input int nb, input int bl);
        exp_t e;
        e.is_done = 1'b1; e.lvl = 1'b0; e.len = 0; e.word = w; e.nbits = nb; e.busy_len = bl;
        sb.push_back(e);
    endtask

    // Full frame: the data word and busy length are supplied as hand-computed constants.
    task automatic push_frame(input logic [31:0] w, input int bl);
        push_seg(1'b0, LLO);
        push_seg(1'b1, LHI);
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b0, BLO);
            push_seg(1'b1, w[i] ? B1 : B0);
        end
        push_seg(1'b0, BLO);
        push_done(w, 32, bl);
    endtask

    task automatic push_repeat();
        push_seg(1'b0, LLO);
        push_seg(1'b1, RHI);
        push_seg(1'b0, BLO);
        push_done(32'h0, 0, 15);
    endtask

    // Monitor: measures runs of ir_tx while busy and checks them against the queue.
    bit          m_lvl;
    int          m_run, m_busy, m_nhigh, m_nbits;
    logic [31:0] m_word;

    task automatic emit(input bit l, input int n);
        exp_t e;
        if (l && m_nhigh > 0) begin
            m_word  = {(n == B1), m_word[31:1]};
            m_nbits++;
        end
        if (l) m_nhigh++;
        if (sb.size() == 0) begin
            chk("sb_underflow_seg", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("segment", {30'b0, 1'b0, l, n}, {30'b0, e.is_done, e.lvl, e.len});
        end
    endtask

    initial begin
        exp_t e;
        m_run = 0; m_busy = 0; m_nhigh = 0; m_nbits = 0; m_word = '0; m_lvl = 1'b1;
        forever begin
            @(negedge clk_50M);
            if (reset) begin
                m_run = 0; m_busy = 0; m_nhigh = 0; m_nbits = 0; m_word = '0;
            end else begin
                if (bus.busy) begin
                    m_busy++;
                    if (m_run == 0) begin
                        m_lvl = bus.ir_tx; m_run = 1;
                    end else if (bus.ir_tx == m_lvl) begin
                        m_run++;
                    end else begin
                        emit(m_lvl, m_run);
                        m_lvl = bus.ir_tx; m_run = 1;
                    end
                end else if (bus.ir_tx !== 1'b1) begin
                    idle_low++;
                end
                if (bus.done) begin
                    if (m_run > 0) emit(m_lvl, m_run);
                    m_run = 0;
                    if (sb.size() == 0) begin
                        chk("sb_underflow_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_kind", 1, e.is_done);
                        chk("busy_len", m_busy, e.busy_len);
                        chk("data_word", m_word, e.word);
                        chk("data_bits", m_nbits, e.nbits);
                    end
                    m_busy = 0; m_nhigh = 0; m_nbits = 0; m_word = '0;
                end
            end
        end
    end

    task automatic drive(input logic [15:0] c, input logic [7:0] k, input bit s, input bit r);
        @(negedge clk_50M);
        bus.customer   = c;
        bus.key        = k;
        bus.start      = s;
        bus.repeat_req = r;
        @(negedge clk_50M);
        bus.start      = 1'b0;
        bus.repeat_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            @(negedge clk_50M);
            if (bus.done) break;
            k++;
        end
        if (k == budget) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.repeat_req = 1'b0; bus.customer = '0; bus.key = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk_50M);
        reset = 1'b0;
        chk("rst_ir", bus.ir_tx, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);

        // Reset asserted mid-frame during the leader high time.
        push_seg(1'b0, LLO);
        drive(16'h3412, 8'h56, 1'b1, 1'b0);
        repeat (10) @(negedge clk_50M);
        chk("pre_rst_ir_high", bus.ir_tx, 1);
        chk("pre_rst_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ir", bus.ir_tx, 1);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_done", bus.done, 0);
        @(negedge clk_50M);
        @(negedge clk_50M);
        reset = 1'b0;
        repeat (5) @(negedge clk_50M);
        chk("post_rst_idle_busy", bus.busy, 0);
        chk("post_rst_idle_ir", bus.ir_tx, 1);

        // Frame 1: bytes 12 34 56 A9, 13 ones.
        push_frame(32'hA9563412, 184);
        drive(16'h3412, 8'h56, 1'b1, 1'b0);
        wait_done(400);

        // Frame 2: bytes 68 B6 F0 0F, 16 ones.
        push_frame(32'h0FF0B668, 193);
        drive(16'hB668, 8'hF0, 1'b1, 1'b0);
        wait_done(400);

        // Repeat code.
        push_repeat();
        drive(16'h0000, 8'h00, 1'b0, 1'b1);
        wait_done(100);

        // Start and key change while busy are ignored.
        push_frame(32'h5AA500FF, 193);
        drive(16'h00FF, 8'hA5, 1'b1, 1'b0);
        repeat (20) @(negedge clk_50M);
        drive(16'hFFFF, 8'h00, 1'b1, 1'b1);
        bus.key = 8'h3C;
        wait_done(400);

        // start and repeat together: full frame wins.
        push_frame(32'h7F800001, 172);
        drive(16'h0001, 8'h80, 1'b1, 1'b1);
        wait_done(400);

        // Back-to-back: new request issued in the done cycle.
        push_repeat();
        drive(16'h0000, 8'h00, 1'b0, 1'b1);
        wait_done(100);
        push_repeat();
        bus.repeat_req = 1'b1;
        @(negedge clk_50M);
        bus.repeat_req = 1'b0;
        chk("b2b_ir_low", bus.ir_tx, 0);
        chk("b2b_busy", bus.busy, 1);
        wait_done(100);

        repeat (5) @(negedge clk_50M);
        chk("sb_empty", sb.size(), 0);
        chk("idle_line_high", idle_low, 0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/nec_ir_tx.md
# nec_ir_tx

NEC-format infrared transmitter. It serialises a 16-bit customer code and an 8-bit key code into a standard NEC frame on a single active-low IR line: leader, 32 data bits LSB-first (the last byte is the bitwise-inverted key), then an end burst. It also supports the NEC repeat code. The block is the transmit counterpart to the board's IRDA_RXD receive path and is used as an on-chip stimulus source and loopback driver. Output is baseband only; there is no 38 kHz carrier.

## Interface

Parameters (all durations in clk_50M cycles; a bench may shrink them):
- LEADER_LO, 450000, leader low time (9 ms)
- LEADER_HI, 225000, leader high time (4.5 ms)
- REPEAT_HI, 112500, repeat-code high time (2.25 ms)
- BIT_LO, 28000, low burst before every data bit and as the end burst (560 us)
- BIT0_HI, 28000, high time for a '0' bit (560 us)
- BIT1_HI, 84500, high time for a '1' bit (1690 us)
- CNT_W, 20, duration counter width; must hold the largest duration parameter

Ports:
- clk_50M  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to send a full frame
- repeat  in  1  single-cycle request to send a repeat code
- customer  in  16  customer code; [7:0] is sent first, then [15:8]
- key  in  8  key code; sent as key, then ~key
- ir_tx  out  1  IR line, idle high, active low
- busy  out  1  high while a frame or repeat code is in progress
- done  out  1  one-cycle pulse when transmission completes

## Operation

- States: IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, END_LO.
- IDLE: ir_tx=1, busy=0. On start, latch the 32-bit shift register {~key, key, customer[15:8], customer[7:0]}, clear the bit index, set the mode to FRAME and go to LEAD_LO. On repeat (with start low), set the mode to REPEAT and go to LEAD_LO.
- If start and repeat are asserted together, start wins.
- LEAD_LO: ir_tx=0 for LEADER_LO cycles. Then go to LEAD_HI.
- LEAD_HI: ir_tx=1 for LEADER_HI cycles in FRAME mode, or REPEAT_HI cycles in REPEAT mode. FRAME mode then goes to BIT_LO; REPEAT mode goes to END_LO.
- BIT_LO: ir_tx=0 for BIT_LO cycles, then go to BIT_HI.
- BIT_HI: ir_tx=1 for BIT1_HI cycles if shreg[0]=1, otherwise BIT0_HI cycles. At exit, shift shreg right by 1 and increment the index. If the index was 31, go to END_LO; otherwise go to BIT_LO.
- END_LO: ir_tx=0 for BIT_LO cycles, then return to IDLE with a done pulse.
- start and repeat are ignored while busy=1. Inputs are sampled only on the accepting cycle, so changes to customer or key mid-frame have no effect.
- The duration counter is loaded with (duration-1) on state entry and decrements to 0; exit happens on the cycle after the count reaches 0.
- Every ir_tx segment lasts exactly its parameter count, with no extra or missing cycles between segments.

## Timing

- Reset values: ir_tx=1, busy=0, done=0, state=IDLE, counter=0, shreg=0. Reset mid-frame returns ir_tx high immediately (asynchronously).
- Latency: start high on rising edge N gives ir_tx=0 and busy=1 from edge N+1.
- ir_tx, busy and done are all registered.
- On the final edge, ir_tx rises to 1, busy falls to 0, and done is 1 for one cycle, all on the same edge.
- A new start can be accepted in the cycle where done=1; that is the first IDLE cycle.
- Full-frame length = LEADER_LO + LEADER_HI + 32·BIT_LO + Σ bit-high times + BIT_LO.
- Repeat-code length = LEADER_LO + REPEAT_HI + BIT_LO.

## Test plan

- Reset state: assert reset mid-frame in LEAD_HI -> ir_tx=1, busy=0 and done=0 asynchronously. After release, the block stays idle until the next start.
- Full frame with defaults: customer=16'h3412, key=8'h56 -> the line decodes as bytes 12, 34, 56, A9 LSB-first (13 ones, 19 zeros). Total busy time is 3,229,500 cycles, and done pulses exactly once.
- Exact segment widths: with a second frame of customer=16'hB668, key=8'hF0 -> the leader low is exactly 450000 cycles and each '1' high is exactly 84500 cycles. Byte 4 is 0F.
- Repeat code: pulse repeat -> 450000 cycles low, 112500 high, 28000 low, then done. busy lasts 590500 cycles.
- Collisions: start pulsed during busy is ignored and the frame is unaltered. start and repeat in the same cycle send a full frame. Changing key mid-frame does not change the output.
- Back-to-back: start asserted in the done cycle -> ir_tx goes low on the next edge, with no idle gap beyond that one cycle.
